// File: rtl/mem_port_arbiter.sv
// Shares one handshaked memory port between instruction fetch and MEM-stage data access.
// Data wins ties. The port stays frozen until mem_ready or the timeout fires.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   input  logic              d_rd,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   output logic              stall_if,
   output logic              stall_mem,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              err
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DATA_BUSY  = 2'd1,
      FETCH_BUSY = 2'd2,
      DONE       = 2'd3
   } state_t;

   localparam int              CNT_W    = 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              mem_req_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              if_valid_q;
   logic              d_valid_q;
   logic              err_q;

   logic              busy_d;
   logic              timeout_d;
   logic              finish_d;
   logic [DATA_W-1:0] cap_data_d;

   // A timed-out access completes like a normal one but returns zero data.
   always_comb begin
      busy_d     = (state_q == DATA_BUSY) || (state_q == FETCH_BUSY);
      timeout_d  = busy_d && !mem_ready && (cnt_q == CNT_LAST);
      finish_d   = busy_d && (mem_ready || timeout_d);
      cap_data_d = mem_ready ? mem_rdata : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         if_valid_q  <= 1'b0;
         d_valid_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         if_valid_q <= 1'b0;
         d_valid_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (d_rd || d_wr) begin
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= d_wr;
                  mem_addr_q  <= d_addr;
                  mem_wdata_q <= d_wdata;
                  cnt_q       <= '0;
                  state_q     <= DATA_BUSY;
               end else if (if_req) begin
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= if_addr;
                  cnt_q      <= '0;
                  state_q    <= FETCH_BUSY;
               end
            end
            DATA_BUSY, FETCH_BUSY: begin
               if (finish_d) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  cnt_q     <= '0;
                  state_q   <= DONE;
                  if (timeout_d) begin
                     err_q <= 1'b1;
                  end
                  if (state_q == DATA_BUSY) begin
                     d_valid_q <= 1'b1;
                     if (!mem_we_q) begin
                        d_rdata_q <= cap_data_d;
                     end
                  end else begin
                     if_valid_q <= 1'b1;
                     if_rdata_q <= cap_data_d;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            // Requesters still hold their completed request here, so nothing is sampled.
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign if_valid  = if_valid_q;
   assign d_valid   = d_valid_q;
   assign err       = err_q;

   assign stall_mem = (d_rd | d_wr) & ~d_valid_q;
   assign stall_if  = (if_req & ~if_valid_q) | stall_mem;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random requesters and a random-latency memory around mem_port_arbiter.
// A timeline model predicts every access window, completion pulse and returned word.
module tb_mem_port_arbiter;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        d_rd = 1'b0;
   logic        d_wr = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [31:0] d_rdata;
   logic        d_valid;
   logic        stall_if;
   logic        stall_mem;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        err;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int txn = 0;

   // Model: one granted access at a time, described by its cycle window.
   int          g_start = -10, g_end = -10, g_valid = -10, next_grant = 0;
   int          g_lat;
   bit          g_data, g_write, g_tmo;
   logic [31:0] g_addr, g_wdata, g_rdata;
   logic [31:0] exp_if_rdata = '0, exp_d_rdata = '0;
   bit          exp_err = 1'b0;
   logic [31:0] mem_arr [logic [31:0]];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return a * 32'h0000_9E37 + 32'h0000_1357;
   endfunction

   function automatic logic [31:0] rand_addr();
      return 32'($urandom_range(0, 31)) << 2;
   endfunction

   task automatic drive_inputs();
      bit in_burst;
      if (cyc - 1 == g_valid) begin
         if (g_data) begin
            d_rd = 1'b0;
            d_wr = 1'b0;
         end else begin
            if_req = 1'b0;
         end
      end
      if (!(d_rd || d_wr) && $urandom_range(0, 2) == 0) begin
         if ($urandom_range(0, 1) == 1) d_wr = 1'b1;
         else d_rd = 1'b1;
         d_addr  = rand_addr();
         d_wdata = $urandom;
      end
      if (!if_req && $urandom_range(0, 2) == 0) begin
         if_req  = 1'b1;
         if_addr = rand_addr();
      end
      // Requesters may scribble on their fields once their access is in flight.
      if (cyc >= g_start && cyc <= g_valid) begin
         if (g_data) begin
            d_addr  = rand_addr();
            d_wdata = $urandom;
         end else begin
            if_addr = rand_addr();
         end
      end
      in_burst = (cyc >= g_start && cyc <= g_end);
      if (in_burst && !g_tmo && cyc == g_start + g_lat - 1) begin
         mem_ready = 1'b1;
         mem_rdata = g_rdata;
      end else begin
         mem_ready = !in_burst && ($urandom_range(0, 3) == 0);
         mem_rdata = $urandom;
      end
   endtask

   task automatic check_cycle();
      bit exp_req, dv, fv, exp_smem, exp_sif;
      int b;
      exp_req = (cyc >= g_start && cyc <= g_end);
      check("mem_req", mem_req, exp_req);
      if (exp_req) begin
         check("mem_addr", mem_addr, g_addr);
         check("mem_we", mem_we, g_write);
         if (g_write) check("mem_wdata", mem_wdata, g_wdata);
      end
      dv = (cyc == g_valid) && g_data;
      fv = (cyc == g_valid) && !g_data;
      if (cyc == g_valid) begin
         if (g_tmo) exp_err = 1'b1;
         if (g_data && !g_write) exp_d_rdata = g_tmo ? 32'h0 : g_rdata;
         if (g_data && g_write && !g_tmo) mem_arr[g_addr] = g_wdata;
         if (!g_data) exp_if_rdata = g_tmo ? 32'h0 : g_rdata;
         txn++;
         $display("txn %0d cyc %0d: %s addr=%h data=%h%s", txn, cyc,
                  !g_data ? "fetch  " : (g_write ? "data-wr" : "data-rd"), g_addr,
                  g_write ? g_wdata : (g_tmo ? 32'h0 : g_rdata), g_tmo ? " timeout" : "");
      end
      check("d_valid", d_valid, dv);
      check("if_valid", if_valid, fv);
      check("d_rdata", d_rdata, exp_d_rdata);
      check("if_rdata", if_rdata, exp_if_rdata);
      check("err", err, exp_err);
      exp_smem = (d_rd || d_wr) && !dv;
      exp_sif  = (if_req && !fv) || exp_smem;
      check("stall_mem", stall_mem, exp_smem);
      check("stall_if", stall_if, exp_sif);
      // Arbiter is free and sees requests: data first, fetch otherwise.
      if (cyc >= next_grant && (d_rd || d_wr || if_req)) begin
         g_data  = d_rd || d_wr;
         g_write = g_data && d_wr;
         g_addr  = g_data ? d_addr : if_addr;
         g_wdata = d_wdata;
         g_rdata = mem_rd(g_addr);
         g_lat   = $urandom_range(1, TO + 2);
         g_tmo   = g_lat > TO;
         b       = g_tmo ? TO : g_lat;
         g_start    = cyc + 1;
         g_end      = cyc + b;
         g_valid    = cyc + b + 1;
         next_grant = cyc + b + 2;
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      #1;
      rst = 1'b1;
      drive_inputs();
      @(negedge clk);
      check_cycle();
   endtask

   task automatic reset_mid_busy();
      int guard = 0;
      while (!(g_data && cyc >= g_start && cyc <= g_end) && guard < 200) begin
         step();
         guard++;
      end
      check("reset_window_found", guard < 200, 1'b1);
      #2 rst = 1'b0;
      #1;
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_d_valid", d_valid, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_d_rdata", d_rdata, 32'h0);
      check("rst_if_rdata", if_rdata, 32'h0);
      g_start = -10; g_end = -10; g_valid = -10;
      exp_err = 1'b0; exp_d_rdata = '0; exp_if_rdata = '0;
      next_grant = cyc + 1;
   endtask

   initial begin
      mem_arr[32'h40] = 32'h8C01_0004;
      repeat (3) @(negedge clk);
      check("init_mem_req", mem_req, 1'b0);
      check("init_mem_we", mem_we, 1'b0);
      check("init_mem_addr", mem_addr, 32'h0);
      check("init_mem_wdata", mem_wdata, 32'h0);
      check("init_if_valid", if_valid, 1'b0);
      check("init_d_valid", d_valid, 1'b0);
      check("init_if_rdata", if_rdata, 32'h0);
      check("init_d_rdata", d_rdata, 32'h0);
      check("init_err", err, 1'b0);
      next_grant = 1;
      for (int r = 0; r < 4; r++) begin
         repeat (300) step();
         reset_mid_busy();
      end
      repeat (150) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates one single-ported, handshaked unified memory between the instruction-fetch stage and the MEM-stage data access of the pipelined MIPS core. It sequences each access through a small FSM and holds the memory interface stable until the memory acknowledges. It returns read data or write acknowledgements to the requester and drives stall signals that freeze the pipeline while an access is outstanding. It sits between the IF/MEM stages and the memory model, in place of their direct memory connections.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, maximum cycles to wait for mem_ready before aborting (1..65535)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held until if_valid
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched instruction
if_valid  out  1  one-cycle fetch completion pulse
d_rd  in  1  data read request; held until d_valid
d_wr  in  1  data write request; held until d_valid; never high together with d_rd
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_rdata  out  DATA_W  read data
d_valid  out  1  one-cycle data completion pulse; asserted for both reads and writes
stall_if  out  1  freeze PC and IF/ID
stall_mem  out  1  freeze the whole pipeline
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ready  in  1  memory completion; read data is valid in the same cycle
mem_rdata  in  DATA_W  memory read data
err  out  1  sticky timeout flag

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. mem_req, mem_we, if_valid, d_valid, err and the timeout counter = 0. mem_addr, mem_wdata, if_rdata, d_rdata = 0. Any in-flight memory access is abandoned; the memory must tolerate mem_req dropping.
- States: IDLE, DATA_BUSY, FETCH_BUSY, DONE.
- IDLE:
  - If (d_rd|d_wr), grant data: next cycle mem_req=1, mem_we=d_wr, mem_addr=d_addr, mem_wdata=d_wdata; go to DATA_BUSY.
  - Else if if_req, grant fetch: mem_req=1, mem_we=0, mem_addr=if_addr; go to FETCH_BUSY.
  - Data always wins a simultaneous request (strict priority, because data belongs to the older instruction).
- BUSY states:
  - mem_req, mem_we, mem_addr and mem_wdata are registered and held constant regardless of requester input changes.
  - The counter increments every cycle.
  - On mem_ready: capture mem_rdata into d_rdata (DATA_BUSY, reads only; writes leave d_rdata unchanged) or into if_rdata (FETCH_BUSY). Next cycle mem_req=0 and the matching valid pulses for exactly one cycle; go to DONE and clear the counter.
  - Timeout: if the counter reaches TIMEOUT without mem_ready, treat it as completion with captured data = 0 and set err=1. err stays set until reset.
- DONE: lasts one cycle. Requests are ignored, because requesters still hold them this cycle. Next state is IDLE.
- mem_ready in IDLE or DONE is ignored.
- Latency: request sampled in IDLE at cycle N; mem_req high from N+1; mem_ready at cycle M>=N+1; valid at M+1; earliest next grant at M+2. Minimum access = 3 cycles.
- Stalls (combinational from registered state):
  - stall_mem = (d_rd|d_wr) & ~d_valid
  - stall_if = (if_req & ~if_valid) | stall_mem
- Outputs if_rdata and d_rdata hold their last value between accesses.

Test Plan:
1. Reset: assert rst=0 mid-DATA_BUSY -> next edge mem_req=0, d_valid=0, err=0, state IDLE; after release, a held d_rd is re-granted.
2. Single fetch: if_req=1, if_addr=0x40, memory returns 0x8C010004 after 2 cycles -> mem_req high for 2 cycles, if_valid one pulse with if_rdata=0x8C010004, stall_if low in that cycle.
3. Collision: if_req and d_rd raised in the same cycle (d_addr=0x100, rdata 0x11) -> data granted first, d_valid with 0x11, then fetch granted at the earliest M+2; stall_if high throughout the data access.
4. Write: d_wr=1, d_addr=0x20, d_wdata=0xCAFEBABE; the requester changes d_wdata mid-access -> mem_wdata stays 0xCAFEBABE, mem_we=1, d_valid pulses, d_rdata unchanged.
5. Back-to-back: requester holds d_rd through the d_valid cycle -> no duplicate access; exactly one mem_req burst per request.
6. Timeout: TIMEOUT=4, mem_ready never asserted -> d_valid after 4 busy cycles with d_rdata=0, err=1 and sticky; a subsequent normal access still completes.
